// File: rtl/chs_pkg.sv
// Shared types and helpers for the cool/heat power controller.
package chs_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RAMP   = 2'd1,
      DRAIN  = 2'd2,
      SWITCH = 2'd3
   } chs_state_e;

   // Power width: enough bits to hold a count of 0..n.
   function automatic int chs_pw(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/chs_popcount.sv
// Combinational population count of the request vector.
module chs_popcount
   import chs_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int PW   = chs_pw(N_IN)
) (
   input  logic [N_IN-1:0] in_vec,
   output logic [PW-1:0]   count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N_IN; i++) begin
         count = count + PW'(in_vec[i]);
      end
   end

endmodule

// File: rtl/chs_power_ctrl.sv
// Slew-limited cool/heat power controller. The target comes from the popcount of the
// accepted request; a mode change drains the power to zero before the mode flips.
//
//   state  | meaning
//   IDLE   | power and mode equal the target
//   RAMP   | mode matches, power stepping toward the target
//   DRAIN  | mode mismatch, power stepping down to zero
//   SWITCH | one cycle, mode takes the target mode
module chs_power_ctrl
   import chs_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int STEP = 1,
   parameter int PW   = chs_pw(N_IN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in,
   output logic            in_ready,
   output logic [PW-1:0]   chs_power,
   output logic            chs_mode,
   output logic            done
);

   localparam logic [PW-1:0] STEP_W = PW'(STEP);

   chs_state_e    state, state_nxt;
   logic [PW-1:0] tgt_power, tgt_power_nxt;
   logic          tgt_mode, tgt_mode_nxt;
   logic [PW-1:0] power_nxt;
   logic          mode_nxt;
   logic [PW-1:0] pop_count;
   logic [PW-1:0] diff;
   logic [PW-1:0] step_ramp;
   logic [PW-1:0] step_drain;
   logic          accept;
   logic          match_now;
   logic          match_nxt;

   chs_popcount #(
      .N_IN (N_IN),
      .PW   (PW)
   ) u_popcount (
      .in_vec (in),
      .count  (pop_count)
   );

   assign in_ready = (state == IDLE) || (state == RAMP);
   assign accept   = in_valid && in_ready;

   // Compare before subtracting so the step never exceeds the remaining distance.
   assign diff       = (tgt_power > chs_power) ? (tgt_power - chs_power) : (chs_power - tgt_power);
   assign step_ramp  = (diff < STEP_W) ? diff : STEP_W;
   assign step_drain = (chs_power < STEP_W) ? chs_power : STEP_W;

   always_comb begin
      state_nxt = state;
      power_nxt = chs_power;
      mode_nxt  = chs_mode;
      case (state)
         IDLE, RAMP: begin
            if (chs_mode != tgt_mode) begin
               state_nxt = DRAIN;
            end else if (chs_power != tgt_power) begin
               if (tgt_power > chs_power) power_nxt = chs_power + step_ramp;
               else                       power_nxt = chs_power - step_ramp;
               state_nxt = (power_nxt == tgt_power) ? IDLE : RAMP;
            end else begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (chs_power != '0) power_nxt = chs_power - step_drain;
            else                 state_nxt = SWITCH;
         end
         SWITCH: begin
            mode_nxt  = tgt_mode;
            state_nxt = (tgt_power == '0) ? IDLE : RAMP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A retarget lands on the same edge as the step, so done must compare against the new target.
   assign tgt_power_nxt = accept ? pop_count    : tgt_power;
   assign tgt_mode_nxt  = accept ? pop_count[0] : tgt_mode;
   assign match_now     = (chs_power == tgt_power) && (chs_mode == tgt_mode);
   assign match_nxt     = (power_nxt == tgt_power_nxt) && (mode_nxt == tgt_mode_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         chs_power <= '0;
         chs_mode  <= 1'b0;
         tgt_power <= '0;
         tgt_mode  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         chs_power <= power_nxt;
         chs_mode  <= mode_nxt;
         tgt_power <= tgt_power_nxt;
         tgt_mode  <= tgt_mode_nxt;
         done      <= !match_now && match_nxt;
      end
   end

endmodule

// File: tb/tb_chs_power_ctrl.sv
// Scenario bench for chs_power_ctrl with N_IN = 8, STEP = 2.
module tb_chs_power_ctrl;

   localparam int N_IN = 8;
   localparam int STEP = 2;
   localparam int PW   = 4;

   typedef struct {
      logic [PW-1:0] p;
      logic          m;
      logic          d;
      logic          r;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic [N_IN-1:0] in_vec;
   logic            in_ready;
   logic [PW-1:0]   chs_power;
   logic            chs_mode;
   logic            done;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;

   chs_power_ctrl #(
      .N_IN (N_IN),
      .STEP (STEP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (in_vec),
      .in_ready  (in_ready),
      .chs_power (chs_power),
      .chs_mode  (chs_mode),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int p, input logic m, input logic d, input logic r);
      exp_t x;
      x.p = PW'(p);
      x.m = m;
      x.d = d;
      x.r = r;
      sb.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      push(0, 0, 0, 1);
      e = sb.pop_front();
      n_vec++;
      if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
         n_err++;
         $display("FAIL reset: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                  chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ramp();
      in_vec = 8'b0000_0110;
      in_valid = 1'b1;
      push(0, 0, 0, 1);
      push(2, 0, 1, 1);
      push(2, 0, 0, 1);
      push(2, 0, 0, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         tick();
         in_valid = 1'b0;
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL ramp[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
   endtask

   task automatic test_redundant();
      in_vec = 8'b1000_0001;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) push(2, 0, 0, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         tick();
         in_valid = 1'b0;
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL redundant[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
   endtask

   task automatic test_mode_change();
      do_reset();
      in_vec = 8'b0111_1111;
      in_valid = 1'b1;
      push(0, 0, 0, 1);
      push(0, 0, 0, 0);
      push(0, 0, 0, 0);
      push(0, 1, 0, 1);
      push(2, 1, 0, 1);
      push(4, 1, 0, 1);
      push(6, 1, 0, 1);
      push(7, 1, 1, 1);
      push(7, 1, 0, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         tick();
         in_valid = 1'b0;
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL mode_change[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
   endtask

   task automatic test_retarget();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            in_vec = 8'hFF;
            in_valid = 1'b1;
            push(0, 0, 0, 1);
         end else if (i == 2) begin
            in_vec = 8'b0000_0011;
            in_valid = 1'b1;
            push(4, 0, 0, 1);
         end else if (i == 1) begin
            push(2, 0, 0, 1);
         end else if (i == 3) begin
            push(2, 0, 1, 1);
         end else begin
            push(2, 0, 0, 1);
         end
         tick();
         in_valid = 1'b0;
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL retarget[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
   endtask

   task automatic test_reset_drain();
      do_reset();
      in_vec = 8'b0011_1111;
      in_valid = 1'b1;
      push(0, 0, 0, 1);
      push(2, 0, 0, 1);
      push(4, 0, 0, 1);
      push(6, 0, 1, 1);
      push(6, 0, 0, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         tick();
         in_valid = 1'b0;
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL drain_setup[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
      in_vec = 8'b0000_0001;
      in_valid = 1'b1;
      push(6, 0, 0, 1);
      push(6, 0, 0, 0);
      push(4, 0, 0, 0);
      for (int i = 0; sb.size() > 0; i++) begin
         tick();
         in_valid = 1'b0;
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL drain[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) push(0, 0, 0, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         if (i == 1) begin
            @(negedge clk);
            rst_n = 1'b1;
         end
         if (i >= 1) tick();
         e = sb.pop_front();
         n_vec++;
         if ({chs_power, chs_mode, done, in_ready} !== {e.p, e.m, e.d, e.r}) begin
            n_err++;
            $display("FAIL drain_reset[%0d]: got p=%0d m=%b d=%b r=%b, want p=%0d m=%b d=%b r=%b",
                     i, chs_power, chs_mode, done, in_ready, e.p, e.m, e.d, e.r);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_vec   = '0;
      #12 rst_n = 1'b1;
      tick();
      test_reset();
      test_ramp();
      test_redundant();
      test_mode_change();
      test_retarget();
      test_reset_drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/chs_power_ctrl.md
# chs_power_ctrl

Sequential, parametrised successor to the combinational cool/heat power decoder. It samples an N-bit request vector through a valid/ready handshake and derives a target power from the number of set bits, with the mode taken from the count's LSB. Output power is slew-limited toward the target. A mode change always forces the power to drain to zero before the mode flips. The block sits between the request-collection logic and the cool/heat actuator drivers.

## Interface
- `N_IN`, default 8: number of request inputs (≥1).
- `STEP`, default 1: maximum change of `chs_power` per clock (1 ≤ STEP ≤ N_IN).
- `PW`, default `$clog2(N_IN+1)`: power width (derived, not overridden).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request vector valid.
- `in` in N_IN: request vector.
- `in_ready` out 1: block accepts a sample this cycle.
- `chs_power` out PW: current applied power.
- `chs_mode` out 1: current mode (1 = odd count, 0 = even count).
- `done` out 1: one-cycle pulse when power and mode reach the target.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`. At that edge, `tgt_power <= popcount(in)` and `tgt_mode <= popcount(in)[0]`.
- States:
  - IDLE: `chs_power == tgt_power && chs_mode == tgt_mode`.
  - RAMP: same mode, power ≠ target.
  - DRAIN: mode mismatch, power going to 0.
  - SWITCH: one cycle, mode flips.
- IDLE/RAMP, mode match, power ≠ target: power moves toward target by `min(STEP, |tgt_power - chs_power|)`. Next state is IDLE if the new power equals the target, otherwise RAMP.
- IDLE/RAMP, mode mismatch: next state is DRAIN; power is unchanged on that edge.
- DRAIN: if `chs_power != 0`, power decreases by `min(STEP, chs_power)` and the state stays DRAIN. If `chs_power == 0`, the next state is SWITCH.
- SWITCH: `chs_mode <= tgt_mode`. Next state is IDLE if `tgt_power == 0`, otherwise RAMP. Power is unchanged.
- `in_ready` = 1 in IDLE and RAMP, 0 in DRAIN and SWITCH. A sample accepted during RAMP retargets immediately; the next edge uses the new target, including a reversal of direction.
- `done` is registered. It is 1 in the cycle after any edge at which (power, mode) transitions from ≠ target to == target. An accept that matches the current state produces no `done`.
- Arithmetic: popcount is width PW, with no overflow because N_IN ≤ 2^PW − 1. Step math is unsigned with a compare-before-subtract; results never wrap.

## Timing
- Reset (async assert, sync release by system) sets:
  - `chs_power` = 0, `chs_mode` = 0, `done` = 0
  - state IDLE, `tgt_power` = 0, `tgt_mode` = 0
  - therefore `in_ready` = 1.
- Latency: an accept at edge k gives the first power change at edge k+1 (same mode).
- A mode change from power P gives: DRAIN entry at k+1, `ceil(P/STEP)` drain edges, one edge into SWITCH, then the mode flip on the following edge.
- Reset asserted mid-operation (any state) clears everything immediately and asynchronously. Any pending target is lost.
- `in_valid` while `in_ready` = 0 is ignored. The sender must hold the sample.

## Structure
- Shared package `chs_pkg`: the state enum (IDLE, RAMP, DRAIN, SWITCH) and the `PW` derivation function.
- One sub-module, `chs_popcount` (combinational, parametrised N_IN → PW), is the generalisation of the legacy counter. It is the only combinational leaf.
- The FSM, target registers, and step datapath live in `chs_power_ctrl`.

## Test plan
Conditions for all scenarios: N_IN = 8, STEP = 2.
- **Reset values:** assert `rst_n` = 0 mid-cycle. Expected immediately: `chs_power` = 0, `chs_mode` = 0, `done` = 0, `in_ready` = 1.
- **Same-mode ramp:** from reset, accept `in` = 8'b0000_0110 at edge k. Expected: `chs_power` = 2 after k+1, `done` = 1 for exactly the one cycle after k+1, `chs_mode` = 0 throughout.
- **Mode change from zero:** from reset, accept 8'b0111_1111 (count 7) at edge k. Expected:
  - k+1 DRAIN, k+2 SWITCH, k+3 `chs_mode` = 1 (RAMP).
  - Power 2, 4, 6, 7 at k+4..k+7, with `done` after k+7.
  - `in_ready` = 0 during the DRAIN and SWITCH cycles.
- **Retarget mid-ramp:** accept 8'hFF (8, mode 0) from power 0 and let power reach 4. Then accept 8'b0000_0011 (count 2). Expected: power goes 4 → 2 on the next edge, then `done`. Power never exceeds 4 after the accept.
- **Reset during DRAIN:** starting from power 6 in mode 0, accept 8'b0000_0001. While in DRAIN at power 4, pulse `rst_n` low. Expected: immediate power 0, mode 0, IDLE. After release there is no further activity without a new accept.
- **Redundant accept:** in IDLE at power 2, mode 0, accept 8'b1000_0001. Expected: no power change, no `done` pulse, `in_ready` stays 1.
